// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, instruction
// field positions and the default boot address.
package inst_fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

    localparam int OPC_LSB = 0;
    localparam int OPC_MSB = 6;
    localparam int F3_LSB  = 12;
    localparam int F3_MSB  = 14;
    localparam int F7_LSB  = 25;
    localparam int F7_MSB  = 31;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        FLUSH = 2'd3
    } fetch_state_e;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_fifo.sv
// Synchronous instruction buffer holding {pc, inst} pairs; flush clears it and
// takes precedence over a same-cycle push.
module inst_fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != DEPTH_C) || do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset: an empty buffer presents zeros through the head mux.
    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= push_data;
    end

    assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: sequential PC requests to instruction memory with a single
// outstanding read, buffered results, and redirect handling from branch resolution.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [6:0]  opcode,
    output logic [2:0]  func3,
    output logic [6:0]  func7
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    fetch_state_e    state;
    fetch_state_e    state_nxt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_nxt;
    logic [XLEN-1:0] req_pc;
    logic            req_fire;
    logic            capture_req;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_flush;
    logic [CW-1:0]   fifo_count;
    logic [2*XLEN-1:0] fifo_head;

    assign imem_req_valid = (state == REQ) && (fifo_count < DEPTH_C);
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign fifo_pop       = inst_valid && inst_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (capture_req)
            req_pc <= pc;
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        capture_req = 1'b0;
        fifo_push   = 1'b0;
        fifo_flush  = 1'b0;

        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                if (req_fire) begin
                    capture_req = 1'b1;
                    pc_nxt      = pc + 32'd4;
                    state_nxt   = WAIT;
                end
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    fifo_push = 1'b1;
                    state_nxt = REQ;
                end
            end
            FLUSH: begin
                if (imem_resp_valid)
                    state_nxt = REQ;
            end
            default: state_nxt = IDLE;
        endcase

        // A redirect wins over everything; FLUSH absorbs a response still owed
        // for a request that was already issued to memory.
        if (redirect_valid) begin
            fifo_flush = 1'b1;
            fifo_push  = 1'b0;
            pc_nxt     = align_pc(redirect_pc);
            case (state)
                IDLE:    state_nxt = REQ;
                REQ:     state_nxt = req_fire ? FLUSH : REQ;
                WAIT:    state_nxt = imem_resp_valid ? REQ : FLUSH;
                FLUSH:   state_nxt = FLUSH;
                default: state_nxt = IDLE;
            endcase
        end
    end

    inst_fetch_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({req_pc, imem_resp_data}),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign inst_valid = (fifo_count != '0);
    assign inst_pc    = fifo_head[2*XLEN-1:XLEN];
    assign inst       = fifo_head[XLEN-1:0];
    assign opcode     = inst[OPC_MSB:OPC_LSB];
    assign func3      = inst[F3_MSB:F3_LSB];
    assign func7      = inst[F7_MSB:F7_LSB];

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: memory model is either a 1-cycle responder or
// driven by hand, with all expected values written out per step.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;

    int n_tests = 0;
    int n_fail  = 0;

    logic        mem_auto;
    logic        mem_addr_data;
    logic        hs_now;
    logic [31:0] hs_addr;

    inst_fetch #(
        .RESET_PC   (32'h8000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .opcode          (opcode),
        .func3           (func3),
        .func7           (func7)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Advance one cycle; the 1-cycle memory answers a request accepted this cycle.
    task automatic tick();
        #1;
        hs_now  = imem_req_valid & imem_req_ready;
        hs_addr = imem_req_addr;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        if (mem_auto) begin
            imem_resp_valid = hs_now;
            imem_resp_data  = mem_addr_data ? hs_addr : 32'h0000_0013;
        end else begin
            imem_resp_valid = 1'b0;
        end
    endtask

    initial begin
        rst             = 1'b1;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        inst_ready      = 1'b0;
        mem_auto        = 1'b1;
        mem_addr_data   = 1'b0;
        hs_now          = 1'b0;
        hs_addr         = '0;

        tick();
        tick();
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_addr", imem_req_addr, 32'h8000_0000);
        check("rst_inst", inst, 0);
        check("rst_inst_pc", inst_pc, 0);
        check("rst_opcode", opcode, 0);

        // Cycle 0: IDLE
        rst = 1'b0;
        check("idle_req_valid", imem_req_valid, 0);
        tick();
        // Cycle 1: first request
        check("c1_req_valid", imem_req_valid, 1);
        check("c1_addr", imem_req_addr, 32'h8000_0000);
        tick();
        check("c2_inst_valid", inst_valid, 0);
        check("c2_req_valid", imem_req_valid, 0);
        tick();
        // Cycle 3: first instruction visible
        check("c3_inst_valid", inst_valid, 1);
        check("c3_inst_pc", inst_pc, 32'h8000_0000);
        check("c3_opcode", opcode, 7'h13);
        check("c3_func3", func3, 0);
        check("c3_func7", func7, 0);
        check("c3_addr", imem_req_addr, 32'h8000_0004);

        // Back-pressure: decode stalls, buffer fills to two
        tick();
        tick();
        check("full_req_valid", imem_req_valid, 0);
        check("full_inst_pc", inst_pc, 32'h8000_0000);
        tick();
        check("full_req_valid_hold", imem_req_valid, 0);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check("pop_req_valid", imem_req_valid, 1);
        check("pop_inst_pc", inst_pc, 32'h8000_0004);
        check("pop_addr", imem_req_addr, 32'h8000_0008);

        // Redirect while WAIT, response arrives the cycle after
        mem_auto = 1'b0;
        tick();
        check("wait_inst_valid", inst_valid, 1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_1000;
        tick();
        check("rdw_inst_valid", inst_valid, 0);
        check("rdw_req_valid", imem_req_valid, 0);
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hDEAD_BEEF;
        tick();
        check("rdw_req_valid2", imem_req_valid, 1);
        check("rdw_addr", imem_req_addr, 32'h8000_1000);
        check("rdw_stale_dropped", inst_valid, 0);
        mem_auto      = 1'b1;
        mem_addr_data = 1'b1;
        tick();
        tick();
        check("rdw_inst_valid2", inst_valid, 1);
        check("rdw_inst_pc", inst_pc, 32'h8000_1000);
        check("rdw_inst", inst, 32'h8000_1000);
        check("rdw_func3", func3, 3'h1);
        check("rdw_func7", func7, 7'h40);
        check("rdw_next_addr", imem_req_addr, 32'h8000_1004);

        // Redirect in the same cycle as a request handshake
        mem_auto       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_2000;
        tick();
        check("rdh_inst_valid", inst_valid, 0);
        check("rdh_req_valid", imem_req_valid, 0);
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h1111_1111;
        tick();
        check("rdh_req_valid2", imem_req_valid, 1);
        check("rdh_addr", imem_req_addr, 32'h8000_2000);
        check("rdh_stale_dropped", inst_valid, 0);
        mem_auto = 1'b1;
        tick();
        tick();
        check("rdh_inst_pc", inst_pc, 32'h8000_2000);

        // Unaligned redirect, with a same-cycle consume
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0102;
        inst_ready     = 1'b1;
        tick();
        inst_ready = 1'b0;
        check("rdu_inst_valid", inst_valid, 0);
        tick();
        check("rdu_addr", imem_req_addr, 32'h8000_0100);

        // Wrap of the PC at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        tick();
        check("wrap_addr_top", imem_req_addr, 32'hFFFF_FFFC);
        tick();
        tick();
        check("wrap_addr_zero", imem_req_addr, 32'h0000_0000);
        check("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
        imem_req_ready = 1'b0;
        tick();
        check("stall_req_valid", imem_req_valid, 1);
        check("stall_addr", imem_req_addr, 32'h0000_0000);

        // Reset asserted mid-WAIT with a buffered entry and a response arriving
        imem_req_ready = 1'b1;
        mem_auto       = 1'b0;
        tick();
        check("rw_inst_valid", inst_valid, 1);
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h2222_2222;
        rst             = 1'b1;
        tick();
        check("rw_inst_valid0", inst_valid, 0);
        check("rw_req_valid0", imem_req_valid, 0);
        check("rw_addr", imem_req_addr, 32'h8000_0000);
        check("rw_inst_pc", inst_pc, 0);
        rst = 1'b0;
        tick();
        check("rw_req_valid1", imem_req_valid, 1);
        check("rw_addr1", imem_req_addr, 32'h8000_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
